// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment count sequencer.
//   state_e    : sequencer mode (MANUAL stepping or AUTO stepping)
//   DIR_UP     : synchronised dir level that selects counting up
//   seg_code_t : 2-bit {A,B} code presented to the decoder
//   step_code  : modulo-4 advance of a code in the requested direction
package seg_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_e;

  localparam logic DIR_UP = 1'b1;

  typedef logic [1:0] seg_code_t;

  // The 2-bit result truncation provides the 3->0 and 0->3 wrap.
  function automatic seg_code_t step_code(input seg_code_t code, input logic dir);
    if (dir == DIR_UP) begin
      return seg_code_t'(code + 2'd1);
    end
    return seg_code_t'(code - 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw push-button: 2-FF synchroniser, stability counter and
// rising-edge detector.
//   clk     : system clock
//   rst     : synchronous active-high reset; clears level and any pending press
//   raw_i   : raw asynchronous, bouncing button (1 = pressed)
//   level_o : debounced level
//   press_o : registered one-cycle pulse on each 0->1 edge of the debounced level
module btn_debounce #(
  parameter int DB_CYCLES = 240_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic          press_q;

  // cnt_q holds how many consecutive samples have disagreed with level_q;
  // the DB_CYCLES-th disagreeing sample flips the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/seg_count_sequencer.sv
// Sequences the 2-bit {A,B} code for the board's 7-segment decoder.
// MANUAL mode steps on each debounced btn_step press; AUTO mode steps every
// TICK_DIV cycles. btn_mode toggles the mode, dir selects up/down counting.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   btn_step : raw step button (1 = pressed)
//   btn_mode : raw mode button (1 = pressed)
//   dir      : raw direction level (1 = up, 0 = down)
//   A, B     : registered count MSB / LSB
//   led      : registered mode indicator (1 = AUTO)
//   tick_o   : one-cycle pulse on each AUTO step, aligned with the code change
module seg_count_sequencer
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 12_000_000,
  parameter int DB_CYCLES = 240_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_step,
  input  logic btn_mode,
  input  logic dir,
  output logic A,
  output logic B,
  output logic led,
  output logic tick_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic step_press;
  logic mode_press;
  logic step_lvl;
  logic mode_lvl;
  logic unused_lvl;

  logic dir_s1_q;
  logic dir_s2_q;

  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  seg_code_t     code_q;
  seg_code_t     code_d;
  logic          tick_q;
  logic          tick_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_step),
    .level_o (step_lvl),
    .press_o (step_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode_db (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_mode),
    .level_o (mode_lvl),
    .press_o (mode_press)
  );

  // Debounced levels are not needed here; only the press pulses drive the FSM.
  assign unused_lvl = step_lvl ^ mode_lvl;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    code_d  = code_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        // Prescaler parked at 0 so AUTO always starts a full period.
        presc_d = '0;
        if (mode_press) begin
          state_d = ST_AUTO;
        end else if (step_press) begin
          code_d = step_code(code_q, dir_s2_q);
        end
      end
      ST_AUTO: begin
        // A mode press beats a coincident terminal count.
        if (mode_press) begin
          state_d = ST_MANUAL;
          presc_d = '0;
        end else if (presc_q == PRE_LAST) begin
          presc_d = '0;
          code_d  = step_code(code_q, dir_s2_q);
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = ST_MANUAL;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_s1_q <= 1'b0;
      dir_s2_q <= 1'b0;
      state_q  <= ST_MANUAL;
      presc_q  <= '0;
      code_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      dir_s1_q <= dir;
      dir_s2_q <= dir_s1_q;
      state_q  <= state_d;
      presc_q  <= presc_d;
      code_q   <= code_d;
      tick_q   <= tick_d;
    end
  end

  assign A      = code_q[1];
  assign B      = code_q[0];
  assign led    = (state_q == ST_AUTO);
  assign tick_o = tick_q;

endmodule

// File: tb/tb_seg_count_sequencer.sv
module tb_seg_count_sequencer;

  localparam int TICK_DIV  = 8;
  localparam int DB_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_step;
  logic btn_mode;
  logic dir;
  logic A;
  logic B;
  logic led;
  logic tick_o;

  always #5 clk = ~clk;

  seg_count_sequencer #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_step (btn_step),
    .btn_mode (btn_mode),
    .dir      (dir),
    .A        (A),
    .B        (B),
    .led      (led),
    .tick_o   (tick_o)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int tick_seen = 0;

  // Reference model state (behavioural, derived from the counting rules)
  bit       m_auto;
  bit [1:0] m_code;
  bit       m_tick;
  int       m_entry;
  bit       raw_s[$];
  bit       raw_m[$];
  bit       raw_d[$];
  bit       smp_s[$];
  bit       smp_m[$];
  bit       lvl_s;
  bit       lvl_m;
  bit       lh_s[$];
  bit       lh_m[$];

  typedef struct {
    bit       rst;
    bit       step;
    bit       mode;
    bit       dir;
    int       ncyc;
    bit [1:0] code;
    bit       led;
    int       ticks;
  } vec_t;

  vec_t tbl[32];
  int   nv = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  function automatic bit window_flip(input bit q[$], input bit lvl);
    if (q.size() < DB_CYCLES) return 1'b0;
    for (int i = 0; i < DB_CYCLES; i++) begin
      if (q[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit [1:0] adv(input bit [1:0] c, input bit up);
    int v;
    v = (int'(c) + (up ? 1 : 3)) % 4;
    return v[1:0];
  endfunction

  task automatic model_reset();
    m_auto = 1'b0;
    m_code = 2'd0;
    m_tick = 1'b0;
    m_entry = 0;
    lvl_s = 1'b0;
    lvl_m = 1'b0;
    raw_s.delete(); raw_m.delete(); raw_d.delete();
    smp_s.delete(); smp_m.delete();
    lh_s.delete(); lh_m.delete();
    repeat (3) begin
      raw_s.push_front(1'b0); raw_m.push_front(1'b0); raw_d.push_front(1'b0);
      lh_s.push_front(1'b0);  lh_m.push_front(1'b0);
    end
  endtask

  // One clock edge of the reference: a press becomes visible to the
  // sequencer two edges after the debounced level rises, and synchronised
  // inputs are the raw values from two edges earlier.
  task automatic model_edge();
    bit ev_s;
    bit ev_m;
    edge_n++;
    if (rst) begin
      model_reset();
      return;
    end
    ev_s = lh_s[1] & ~lh_s[2];
    ev_m = lh_m[1] & ~lh_m[2];
    raw_s.push_front(btn_step); raw_m.push_front(btn_mode); raw_d.push_front(dir);
    while (raw_s.size() > 3) void'(raw_s.pop_back());
    while (raw_m.size() > 3) void'(raw_m.pop_back());
    while (raw_d.size() > 3) void'(raw_d.pop_back());
    smp_s.push_front(raw_s[2]); smp_m.push_front(raw_m[2]);
    while (smp_s.size() > DB_CYCLES) void'(smp_s.pop_back());
    while (smp_m.size() > DB_CYCLES) void'(smp_m.pop_back());
    if (window_flip(smp_s, lvl_s)) lvl_s = ~lvl_s;
    if (window_flip(smp_m, lvl_m)) lvl_m = ~lvl_m;
    lh_s.push_front(lvl_s); lh_m.push_front(lvl_m);
    while (lh_s.size() > 3) void'(lh_s.pop_back());
    while (lh_m.size() > 3) void'(lh_m.pop_back());
    m_tick = 1'b0;
    if (ev_m) begin
      m_auto = ~m_auto;
      if (m_auto) m_entry = edge_n;
    end else if (!m_auto && ev_s) begin
      m_code = adv(m_code, raw_d[2]);
    end else if (m_auto && ((edge_n - m_entry) % TICK_DIV == 0)) begin
      m_code = adv(m_code, raw_d[2]);
      m_tick = 1'b1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_code", {6'd0, A, B}, {6'd0, m_code});
    check("model_led", {7'd0, led}, {7'd0, m_auto});
    check("model_tick", {7'd0, tick_o}, {7'd0, m_tick});
    if (tick_o === 1'b1) tick_seen++;
  endtask

  task automatic add(input bit r, input bit s, input bit m, input bit d, input int n,
                     input bit [1:0] c, input bit l, input int t);
    tbl[nv] = '{rst: r, step: s, mode: m, dir: d, ncyc: n, code: c, led: l, ticks: t};
    nv++;
  endtask

  initial begin
    rst = 1'b1;
    btn_step = 1'b0;
    btn_mode = 1'b0;
    dir = 1'b0;
    model_reset();

    //   rst step mode dir ncyc code led ticks
    add(1, 0, 0, 0,  3, 2'd0, 0, 0);  // reset
    add(0, 0, 0, 0, 20, 2'd0, 0, 0);  // idle after reset
    add(0, 1, 0, 1, 10, 2'd1, 0, 0);  // manual up presses
    add(0, 0, 0, 1, 10, 2'd1, 0, 0);
    add(0, 1, 0, 1, 10, 2'd2, 0, 0);
    add(0, 0, 0, 1, 10, 2'd2, 0, 0);
    add(0, 1, 0, 1, 10, 2'd3, 0, 0);
    add(0, 0, 0, 1, 10, 2'd3, 0, 0);
    add(0, 1, 0, 1, 10, 2'd0, 0, 0);  // up wrap 3->0
    add(0, 0, 0, 1, 10, 2'd0, 0, 0);
    add(0, 1, 0, 1,  2, 2'd0, 0, 0);  // bounce
    add(0, 0, 0, 1,  2, 2'd0, 0, 0);
    add(0, 1, 0, 1,  2, 2'd0, 0, 0);
    add(0, 0, 0, 1, 10, 2'd0, 0, 0);
    add(0, 0, 1, 0, 10, 2'd0, 1, 0);  // enter AUTO, counting down
    add(0, 0, 0, 0,  6, 2'd3, 1, 1);  // down wrap 0->3
    add(0, 0, 0, 0,  8, 2'd2, 1, 1);
    add(0, 1, 0, 0, 10, 2'd1, 1, 1);  // step press ignored in AUTO
    add(0, 0, 0, 0,  6, 2'd0, 1, 1);
    add(0, 0, 1, 0, 10, 2'd0, 0, 0);  // mode press on terminal count
    add(0, 0, 0, 0, 10, 2'd0, 0, 0);
    add(0, 1, 0, 0, 10, 2'd3, 0, 0);  // manual step after collision
    add(0, 0, 0, 0, 10, 2'd3, 0, 0);

    for (int i = 0; i < nv; i++) begin
      rst = tbl[i].rst;
      btn_step = tbl[i].step;
      btn_mode = tbl[i].mode;
      dir = tbl[i].dir;
      tick_seen = 0;
      repeat (tbl[i].ncyc) cyc();
      check($sformatf("vec%0d_code", i), {6'd0, A, B}, {6'd0, tbl[i].code});
      check($sformatf("vec%0d_led", i), {7'd0, led}, {7'd0, tbl[i].led});
      check($sformatf("vec%0d_ticks", i), 8'(tick_seen), 8'(tbl[i].ticks));
    end

    // Exact press-to-output latency, including the up wrap 3->0.
    dir = 1'b1;
    repeat (4) cyc();
    btn_step = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check($sformatf("latency_c%0d", i), {6'd0, A, B}, (i < 8) ? 8'd3 : 8'd0);
    end
    repeat (2) cyc();
    btn_step = 1'b0;
    repeat (10) cyc();

    // Mid-run reset while in AUTO at code 10.
    btn_mode = 1'b1;
    repeat (10) cyc();
    btn_mode = 1'b0;
    repeat (14) cyc();
    check("midrst_pre_code", {6'd0, A, B}, 8'd2);
    check("midrst_pre_led", {7'd0, led}, 8'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_code", {6'd0, A, B}, 8'd0);
    check("midrst_led", {7'd0, led}, 8'd0);
    tick_seen = 0;
    repeat (8) cyc();
    check("midrst_ticks", 8'(tick_seen), 8'd0);
    check("midrst_led_after", {7'd0, led}, 8'd0);

    // Randomised stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 6) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      rst = ($urandom_range(0, 249) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
